// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcodes, sequencer states, defaults.
package cpu_pkg;

    localparam int unsigned OPW_DEF     = 3;
    localparam int unsigned TIMEOUT_DEF = 15;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_LDA = 3'd1;
    localparam logic [2:0] OP_STA = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_JMP = 3'd6;
    localparam logic [2:0] OP_JZ  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD_IR = 3'd2,
        S_DECODE  = 3'd3,
        S_MEM     = 3'd4,
        S_ALU     = 3'd5,
        S_HALT    = 3'd6
    } state_t;

endpackage

// File: rtl/wait_timer.sv
// Memory wait-state counter; expired is high while the count sits at TIMEOUT-1.
module wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_nxt;
    logic          r_expired;

    always_comb begin
        w_nxt = r_cnt;
        if (clr) begin
            w_nxt = '0;
        end else if (en) begin
            w_nxt = r_cnt + CW'(1);
        end
    end

    // expired tracks the registered count so it is glitch-free at the FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_expired <= 1'b0;
        end else begin
            r_cnt     <= w_nxt;
            r_expired <= (w_nxt == CW'(TIMEOUT - 1));
        end
    end

    assign expired = r_expired;

endmodule

// File: rtl/instr_sequencer.sv
// Opcode-driven fetch/decode/execute sequencer with memory-ready handshake and bus-error timeout.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned OPW     = OPW_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pc_en,
    output logic           pc_load,
    output logic           ir_en,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           addr_sel,
    output logic           alu_en,
    output logic           acc_en,
    output logic           halted,
    output logic           bus_err
);

    state_t         r_state;
    logic [OPW-1:0] r_op;
    logic           r_bus_err;
    logic           w_waiting;
    logic           w_expired;
    logic           w_clr;
    logic           w_en;

    // Counter is held at zero outside the wait states, so every entry starts fresh
    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_clr     = !w_waiting || mem_ready || w_expired;
    assign w_en      = w_waiting && !mem_ready;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .en      (w_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_bus_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_LOAD_IR;
                    end else if (w_expired) begin
                        r_state   <= S_HALT;
                        r_bus_err <= 1'b1;
                    end
                end
                S_LOAD_IR: r_state <= S_DECODE;
                S_DECODE: begin
                    r_op <= opcode;
                    if (opcode == OPW'(OP_HLT)) begin
                        r_state <= S_HALT;
                    end else if ((opcode == OPW'(OP_JMP)) || (opcode == OPW'(OP_JZ))) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        r_state <= (r_op == OPW'(OP_STA)) ? S_FETCH : S_ALU;
                    end else if (w_expired) begin
                        r_state   <= S_HALT;
                        r_bus_err <= 1'b1;
                    end
                end
                S_ALU: r_state <= S_FETCH;
                S_HALT: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_bus_err <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Moore decode of the state register; DECODE also looks at opcode/zero for jumps
    always_comb begin
        pc_en    = 1'b0;
        pc_load  = 1'b0;
        ir_en    = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        addr_sel = 1'b0;
        alu_en   = 1'b0;
        acc_en   = 1'b0;
        halted   = 1'b0;
        case (r_state)
            S_FETCH: mem_rd = 1'b1;
            S_LOAD_IR: begin
                ir_en = 1'b1;
                pc_en = 1'b1;
            end
            S_DECODE: begin
                if (opcode == OPW'(OP_JMP)) begin
                    pc_load  = 1'b1;
                    addr_sel = 1'b1;
                end else if (opcode == OPW'(OP_JZ)) begin
                    pc_load  = zero;
                    addr_sel = 1'b1;
                end
            end
            S_MEM: begin
                addr_sel = 1'b1;
                if (r_op == OPW'(OP_STA)) mem_wr = 1'b1;
                else                      mem_rd = 1'b1;
            end
            S_ALU: begin
                alu_en = 1'b1;
                acc_en = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign bus_err = r_bus_err;

endmodule
